// File: rtl/sram_bridge_pkg.sv
// Shared types and widths for the SRAM strobe to request bridge.
package sram_bridge_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StReq,
    StDone,
    StHold
  } state_e;

endpackage

// File: rtl/sram_req_bridge_if.sv
// Request/acknowledge bus between the bridge (master) and the ssdram controller (slave).
interface sram_req_bridge_if;
  import sram_bridge_pkg::*;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_we_o;
  logic              mem_req_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  modport master (
    output mem_addr_o, mem_data_o, mem_we_o, mem_req_o,
    input  mem_ack_i, mem_data_i
  );

  modport slave (
    input  mem_addr_o, mem_data_o, mem_we_o, mem_req_o,
    output mem_ack_i, mem_data_i
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit flop-chain synchroniser with a configurable reset level.
module cdc_sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sram_req_bridge.sv
// Turns asynchronous CPU SRAM strobes into one request/ack transaction per access,
// freezing address/data at capture and holding read data for the CPU.
module sram_req_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [DATA_W-1:0]  cpu_data_i,
  input  logic               cpu_cs_n_i,
  input  logic               cpu_oe_n_i,
  input  logic               cpu_we_n_i,
  output logic [DATA_W-1:0]  cpu_data_o,
  sram_req_bridge_if.master  mem,
  output logic               timeout_o,
  output logic               busy_o
);

  logic cs_n_s, oe_n_s, we_n_s;

  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock_i), .reset(reset_i), .d(cpu_cs_n_i), .q(cs_n_s)
  );
  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oe (
    .clock(clock_i), .reset(reset_i), .d(cpu_oe_n_i), .q(oe_n_s)
  );
  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_we (
    .clock(clock_i), .reset(reset_i), .d(cpu_we_n_i), .q(we_n_s)
  );

  logic access, is_wr;
  assign access = !cs_n_s && (!oe_n_s || !we_n_s);
  assign is_wr  = !we_n_s;  // we wins when both strobes are low

  state_e            state_q, state_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic              settle_wr_q, settle_wr_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    settle_wr_d  = settle_wr_q;
    tmo_cnt_d    = tmo_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
          settle_wr_d  = is_wr;
        end
      end
      StSettle: begin
        if (!access) begin
          state_d = StIdle;
        end else if (is_wr != settle_wr_q) begin
          settle_cnt_d = '0;
          settle_wr_d  = is_wr;
        end else if (settle_cnt_q == 4'(SETTLE_CYC)) begin
          addr_d    = cpu_addr_i;
          wdata_d   = cpu_data_i;
          we_d      = settle_wr_q;
          tmo_cnt_d = '0;
          state_d   = StReq;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StReq: begin
        // ssdram cannot abort, so a dropped strobe does not end the request
        if (mem.mem_ack_i) begin
          if (!we_q) rdata_d = mem.mem_data_i;
          state_d = StDone;
        end else if (tmo_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = StHold;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StDone: state_d = StHold;
      StHold: begin
        if (!access) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      settle_wr_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      settle_wr_q  <= settle_wr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem.mem_req_o  = (state_q == StReq);
  assign mem.mem_addr_o = addr_q;
  assign mem.mem_data_o = wdata_q;
  assign mem.mem_we_o   = we_q;
  assign cpu_data_o     = rdata_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed self-checking bench for sram_req_bridge with default parameters.
module tb_sram_req_bridge;
  import sram_bridge_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cs_n, oe_n, we_n;
  logic [DATA_W-1:0] cpu_rdata;
  logic              timeout, busy;

  int n_checks = 0;
  int n_pass   = 0;

  sram_req_bridge_if bus ();

  sram_req_bridge #(
    .SYNC_STAGES(2),
    .SETTLE_CYC (2),
    .TIMEOUT_CYC(255)
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata),
    .cpu_cs_n_i(cs_n),
    .cpu_oe_n_i(oe_n),
    .cpu_we_n_i(we_n),
    .cpu_data_o(cpu_rdata),
    .mem       (bus),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic release_bus();
    cs_n = 1'b1;
    oe_n = 1'b1;
    we_n = 1'b1;
  endtask

  int req_cnt, to_cnt, to_tick, first_low;

  initial begin
    rst = 1'b1;
    cpu_addr = '0;
    cpu_wdata = '0;
    release_bus();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    tick(3);
    check_eq("rst_req", 32'(bus.mem_req_o), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we_o), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_addr_o), 32'd0);
    check_eq("rst_cpu_data", 32'(cpu_rdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick(2);

    // Read 0x1A2B3
    cpu_addr = 19'h1A2B3;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick(5);
    check_eq("rd_req_early", 32'(bus.mem_req_o), 32'd0);
    tick();
    check_eq("rd_req_lat5", 32'(bus.mem_req_o), 32'd1);
    check_eq("rd_we", 32'(bus.mem_we_o), 32'd0);
    check_eq("rd_addr", 32'(bus.mem_addr_o), 32'h1A2B3);
    tick(2);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 8'h5C;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = 8'h00;
    check_eq("rd_req_released", 32'(bus.mem_req_o), 32'd0);
    check_eq("rd_cpu_data", 32'(cpu_rdata), 32'h5C);
    release_bus();
    tick(3);
    check_eq("rd_idle", 32'(busy), 32'd0);

    // Write with both strobes low
    cpu_addr = 19'h00010;
    cpu_wdata = 8'hA5;
    cs_n = 1'b0;
    oe_n = 1'b0;
    we_n = 1'b0;
    tick(6);
    check_eq("wr_req", 32'(bus.mem_req_o), 32'd1);
    check_eq("wr_we", 32'(bus.mem_we_o), 32'd1);
    check_eq("wr_data", 32'(bus.mem_data_o), 32'hA5);
    check_eq("wr_addr", 32'(bus.mem_addr_o), 32'h00010);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 8'h33;
    tick();
    bus.mem_ack_i = 1'b0;
    check_eq("wr_req_released", 32'(bus.mem_req_o), 32'd0);
    check_eq("wr_cpu_data_kept", 32'(cpu_rdata), 32'h5C);
    release_bus();
    tick(3);
    check_eq("wr_idle", 32'(busy), 32'd0);

    // Two-cycle oe glitch must not produce a request
    cpu_addr = 19'h00777;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick(2);
    oe_n = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.mem_req_o) req_cnt++;
    end
    check_eq("glitch_no_req", 32'(req_cnt), 32'd0);
    check_eq("glitch_idle", 32'(busy), 32'd0);
    release_bus();
    tick(2);

    // Strobe released while the request is outstanding
    cpu_addr = 19'h7FFFF;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick(6);
    check_eq("mid_req", 32'(bus.mem_req_o), 32'd1);
    release_bus();
    tick(3);
    check_eq("mid_req_held", 32'(bus.mem_req_o), 32'd1);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 8'hE7;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = 8'h00;
    check_eq("mid_req_released", 32'(bus.mem_req_o), 32'd0);
    check_eq("mid_cpu_data", 32'(cpu_rdata), 32'hE7);
    tick(2);
    check_eq("mid_idle_2cyc", 32'(busy), 32'd0);

    // Timeout: no ack at all
    cpu_addr = 19'h0ABCD;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick(6);
    check_eq("to_req", 32'(bus.mem_req_o), 32'd1);
    req_cnt = 1;
    to_cnt = 0;
    to_tick = -1;
    first_low = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.mem_req_o) req_cnt++;
      if (timeout) begin
        to_cnt++;
        to_tick = i;
      end
      if (!bus.mem_req_o && first_low < 0) first_low = i;
    end
    check_eq("to_req_cycles", 32'(req_cnt), 32'd255);
    check_eq("to_pulse_count", 32'(to_cnt), 32'd1);
    check_eq("to_pulse_pos", 32'(to_tick), 32'd254);
    check_eq("to_req_fall_pos", 32'(first_low), 32'd254);
    check_eq("to_cpu_data_kept", 32'(cpu_rdata), 32'hE7);
    check_eq("to_holding", 32'(busy), 32'd1);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 8'h11;
    tick();
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = 8'h00;
    tick();
    check_eq("late_ack_ignored", 32'(cpu_rdata), 32'hE7);
    release_bus();
    tick(3);
    check_eq("to_idle", 32'(busy), 32'd0);

    // Reset while requesting
    cpu_addr = 19'h12345;
    cpu_wdata = 8'h9E;
    cs_n = 1'b0;
    we_n = 1'b0;
    tick(6);
    check_eq("rr_req", 32'(bus.mem_req_o), 32'd1);
    check_eq("rr_addr", 32'(bus.mem_addr_o), 32'h12345);
    rst = 1'b1;
    tick();
    check_eq("rr_req_low", 32'(bus.mem_req_o), 32'd0);
    check_eq("rr_addr_clr", 32'(bus.mem_addr_o), 32'd0);
    check_eq("rr_data_clr", 32'(bus.mem_data_o), 32'd0);
    check_eq("rr_we_clr", 32'(bus.mem_we_o), 32'd0);
    check_eq("rr_cpu_data_clr", 32'(cpu_rdata), 32'd0);
    check_eq("rr_busy", 32'(busy), 32'd0);
    check_eq("rr_timeout", 32'(timeout), 32'd0);
    release_bus();
    tick();
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
